latency_dram: RTL and testbench

LATENCY_DRAM -- requirements
Module: latency_dram

---
 rtl/latency_dram_pkg.sv | 20 ++
 rtl/dram_delay_cnt.sv | 29 ++
 rtl/latency_dram.sv | 125 ++++++++++++
 tb/tb_latency_dram.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/latency_dram_pkg.sv
// rtl/latency_dram_pkg.sv - shared state encoding and clog2 helper for the latency DRAM model
package latency_dram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   // Ceiling log2; clog2(1) is 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dram_delay_cnt.sv
// rtl/dram_delay_cnt.sv - loadable down-counter that flags the last wait cycle
module dram_delay_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load on acceptance, count down while waiting, park at zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // The edge that sees a count of one is the edge that leaves WAIT.
   assign done = (cnt == W'(1));

endmodule

// File: rtl/latency_dram.sv
// rtl/latency_dram.sv - fixed-latency line memory with masked writes and range checking
module latency_dram
   import latency_dram_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int MEM_SIZE   = 512,
   parameter int DELAY      = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              addr_i,
   input  logic [DATA_WIDTH-1:0]    data_i,
   input  logic                     cs,
   input  logic                     we,
   input  logic [DATA_WIDTH/32-1:0] wmask_i,
   output logic                     ack,
   output logic [DATA_WIDTH-1:0]    data_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int NW       = DATA_WIDTH / 32;
   localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);
   localparam int IDX_W    = clog2(MEM_SIZE);
   localparam int CNT_W    = clog2(DELAY) + 1;
   localparam logic [63:0] HI_MASK64 = ~((64'd1 << (ADDR_LSB + IDX_W)) - 64'd1);
   localparam logic [31:0] HI_MASK   = HI_MASK64[31:0];

   logic [DATA_WIDTH-1:0] memory [0:MEM_SIZE-1];

   state_t                state;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  we_q;
   logic [NW-1:0]         wmask_q;
   logic                  oor_q;

   logic                  accept;
   logic                  enter_ack;
   logic                  cnt_done;
   logic                  in_oor;
   logic [IDX_W-1:0]      eff_idx;
   logic [DATA_WIDTH-1:0] eff_data;
   logic                  eff_we;
   logic [NW-1:0]         eff_mask;
   logic                  eff_oor;
   logic                  unused_addr_lsb;

   assign unused_addr_lsb = ^addr_i[ADDR_LSB-1:0];
   assign in_oor          = |(addr_i & HI_MASK);
   assign accept          = (state == IDLE) && cs;

   // With DELAY=1 the commit edge is the accepting edge, so the live inputs
   // stand in for the not-yet-latched request.
   assign eff_idx   = (state == IDLE) ? addr_i[ADDR_LSB +: IDX_W] : idx_q;
   assign eff_data  = (state == IDLE) ? data_i  : data_q;
   assign eff_we    = (state == IDLE) ? we      : we_q;
   assign eff_mask  = (state == IDLE) ? wmask_i : wmask_q;
   assign eff_oor   = (state == IDLE) ? in_oor  : oor_q;
   assign enter_ack = ((DELAY == 1) && accept) || ((state == WAIT) && cnt_done);

   dram_delay_cnt #(
      .W (CNT_W)
   ) u_delay_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (CNT_W'(DELAY - 1)),
      .dec      (state == WAIT),
      .done     (cnt_done)
   );

   // Request FSM with registered ack/err/busy/read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         ack    <= 1'b0;
         busy_o <= 1'b0;
         err_o  <= 1'b0;
         data_o <= '0;
      end else begin
         ack   <= 1'b0;
         err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (cs) begin
                  idx_q   <= addr_i[ADDR_LSB +: IDX_W];
                  data_q  <= data_i;
                  we_q    <= we;
                  wmask_q <= wmask_i;
                  oor_q   <= in_oor;
                  state   <= (DELAY == 1) ? ACK : WAIT;
                  busy_o  <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_done) state <= ACK;
            end
            ACK: begin
               state  <= IDLE;
               ack    <= 1'b1;
               err_o  <= oor_q;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
         if (enter_ack && !eff_we) begin
            data_o <= eff_oor ? '0 : memory[eff_idx];
         end
      end
   end

   // Masked line write; memory contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && enter_ack && eff_we && !eff_oor) begin
         for (int j = 0; j < NW; j++) begin
            if (eff_mask[j]) memory[eff_idx][j*32 +: 32] <= eff_data[j*32 +: 32];
         end
      end
   end

endmodule

// File: tb/tb_latency_dram.sv
// tb/tb_latency_dram.sv - randomized self-checking bench for latency_dram against a line-array model
module tb_latency_dram;

   logic         clk = 1'b0;
   logic         rst, rst1;
   logic [31:0]  addr, addr1;
   logic [255:0] wdata, wdata1;
   logic         cs, cs1, we, we1;
   logic [7:0]   wmask, wmask1;
   logic         ack, ack1, busy, busy1, err, err1;
   logic [255:0] rdata, rdata1;

   int           tests = 0;
   int           fails = 0;
   int           cyc   = 0;
   logic [255:0] model_mem [0:511];
   logic [255:0] last_rd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   latency_dram #(.DATA_WIDTH(256), .MEM_SIZE(512), .DELAY(10)) dut (
      .clk(clk), .rst(rst), .addr_i(addr), .data_i(wdata), .cs(cs), .we(we),
      .wmask_i(wmask), .ack(ack), .data_o(rdata), .busy_o(busy), .err_o(err)
   );

   latency_dram #(.DATA_WIDTH(256), .MEM_SIZE(512), .DELAY(1)) dut1 (
      .clk(clk), .rst(rst1), .addr_i(addr1), .data_i(wdata1), .cs(cs1), .we(we1),
      .wmask_i(wmask1), .ack(ack1), .data_o(rdata1), .busy_o(busy1), .err_o(err1)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One full transaction on the DELAY=10 instance, checked against the model.
   task automatic txn(input logic [31:0] a, input logic [255:0] d, input logic w, input logic [7:0] m);
      logic       oor;
      logic [8:0] idx;
      oor = (a[31:14] != 18'd0);
      idx = a[13:5];
      @(negedge clk);
      addr = a; wdata = d; we = w; wmask = m; cs = 1'b1;
      @(posedge clk); #1;
      cs = 1'b0;
      chk("busy_in_flight", {255'd0, busy}, 256'd1);
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
         chk("ack_early", {255'd0, ack}, 256'd0);
      end
      if (w && !oor) begin
         for (int j = 0; j < 8; j++)
            if (m[j]) model_mem[idx][j*32 +: 32] = d[j*32 +: 32];
      end
      if (!w) last_rd = oor ? 256'd0 : model_mem[idx];
      @(posedge clk); #1;
      chk("ack", {255'd0, ack}, 256'd1);
      chk("err", {255'd0, err}, {255'd0, oor});
      chk("data_o", rdata, last_rd);
   endtask

   initial begin
      int          n_ack;
      int          stamps[$];
      logic [255:0] v0;
      logic [31:0] ra;

      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           n_ack;
      int           stamps[$];
      logic [255:0] v0;
      logic [31:0]  ra;

      rst = 1'b0; rst1 = 1'b0;
      cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
      cs1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; wmask1 = '0;
      last_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {255'd0, ack}, 256'd0);
      chk("rst_busy", {255'd0, busy}, 256'd0);
      chk("rst_err", {255'd0, err}, 256'd0);
      chk("rst_data", rdata, 256'd0);
      chk("rst1_ack", {255'd0, ack1}, 256'd0);
      chk("rst1_data", rdata1, 256'd0);
      @(negedge clk);
      rst = 1'b1; rst1 = 1'b1;

      // Read timing on line 0.
      txn(32'h0, 256'h5, 1'b1, 8'hFF);
      txn(32'h0, 256'h0, 1'b0, 8'h00);
      chk("read5", rdata, 256'h5);

      // Masked write of the low word only.
      txn(32'h20, 256'h0, 1'b1, 8'hFF);
      txn(32'h20, {256{1'b1}}, 1'b1, 8'h01);
      txn(32'h20, 256'h0, 1'b0, 8'h00);
      chk("masked_value", rdata, {224'd0, 32'hFFFF_FFFF});

      // Zero mask write is a no-op.
      txn(32'h20, rnd256(), 1'b1, 8'h00);
      txn(32'h20, 256'h0, 1'b0, 8'h00);

      // Out-of-range accesses.
      txn(32'h4000, 256'h0, 1'b0, 8'h00);
      @(posedge clk); #1;
      chk("err_after_ack", {255'd0, err}, 256'd0);
      txn(32'h4000, {256{1'b1}}, 1'b1, 8'hFF);
      chk("oor_mem0", dut.memory[0], 256'h5);

      // Second cs pulse during WAIT is ignored.
      @(negedge clk);
      addr = 32'h0; we = 1'b0; cs = 1'b1;
      @(posedge clk); #1;
      cs = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); cs = 1'b1;
      @(negedge clk); cs = 1'b0;
      n_ack = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (ack) n_ack++;
      end
      chk("one_ack", n_ack, 1);
      last_rd = model_mem[0];

      // cs held high: acks every DELAY+1 cycles.
      @(negedge clk);
      addr = 32'h0; we = 1'b0; cs = 1'b1;
      stamps.delete();
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (ack) stamps.push_back(cyc);
      end
      cs = 1'b0;
      repeat (15) @(posedge clk);
      chk("held_count", {255'd0, stamps.size() >= 3}, 256'd1);
      for (int i = 1; i < stamps.size(); i++)
         chk("held_spacing", stamps[i] - stamps[i-1], 11);

      // Reset in the middle of a write to line 3, with cs also high.
      v0 = rnd256();
      txn(32'h60, v0, 1'b1, 8'hFF);
      @(negedge clk);
      addr = 32'h60; wdata = ~v0; we = 1'b1; wmask = 8'hFF; cs = 1'b1;
      @(posedge clk); #1;
      cs = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; cs = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", {255'd0, busy}, 256'd0);
      chk("midrst_ack", {255'd0, ack}, 256'd0);
      chk("midrst_data", rdata, 256'd0);
      @(negedge clk);
      rst = 1'b1; cs = 1'b0;
      n_ack = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (ack || busy) n_ack++;
      end
      chk("midrst_quiet", n_ack, 0);
      chk("midrst_mem3", dut.memory[3], model_mem[3]);
      last_rd = '0;

      // Randomized traffic over 16 initialised lines with occasional bad addresses.
      for (int i = 0; i < 16; i++) txn({18'd0, 9'(i), 5'd0}, rnd256(), 1'b1, 8'hFF);
      for (int i = 0; i < 40; i++) begin
         ra = {18'd0, 9'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
         if ($urandom_range(0, 7) == 0) ra[$urandom_range(14, 31)] = 1'b1;
         txn(ra, rnd256(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      // DELAY=1 instance: write, read, then back-to-back spacing.
      v0 = rnd256();
      @(negedge clk);
      addr1 = 32'h40; wdata1 = v0; we1 = 1'b1; wmask1 = 8'hFF; cs1 = 1'b1;
      @(posedge clk); #1;
      cs1 = 1'b0;
      chk("d1_wr_noack", {255'd0, ack1}, 256'd0);
      @(posedge clk); #1;
      chk("d1_wr_ack", {255'd0, ack1}, 256'd1);
      @(negedge clk);
      we1 = 1'b0; cs1 = 1'b1;
      @(posedge clk); #1;
      cs1 = 1'b0;
      chk("d1_rd_noack", {255'd0, ack1}, 256'd0);
      @(posedge clk); #1;
      chk("d1_rd_ack", {255'd0, ack1}, 256'd1);
      chk("d1_rd_data", rdata1, v0);
      chk("d1_rd_err", {255'd0, err1}, 256'd0);
      @(negedge clk);
      cs1 = 1'b1;
      stamps.delete();
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (ack1) stamps.push_back(cyc);
      end
      cs1 = 1'b0;
      chk("d1_held_count", {255'd0, stamps.size() >= 4}, 256'd1);
      for (int i = 1; i < stamps.size(); i++)
         chk("d1_held_spacing", stamps[i] - stamps[i-1], 2);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
